// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 controller.
package spi_pkg;

  localparam int SPI_MODE = 0;
  localparam logic CPOL = 1'((SPI_MODE >> 1) & 1);
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    BURST_WAIT,
    GAP
  } state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI controller: ticks every clk_div+1 cycles while
// enabled and owns the SCLK flop so it can be cleared asynchronously by reset.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             restart,
  input  logic             enable,
  input  logic             toggle_en,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             rise,
  output logic             fall,
  output logic             sclk
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  assign tick = enable && (cnt == '0);
  assign rise = tick && toggle_en && !sclk;
  assign fall = tick && toggle_en && sclk;

  // The divider is captured only on an IDLE accept so a burst keeps one rate.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      cnt   <= '0;
      sclk  <= 1'b0;
    end else begin
      if (load) begin
        div_q <= div;
        cnt   <= div;
      end else if (restart) begin
        cnt <= div_q;
      end else if (enable) begin
        cnt <= (cnt == '0) ? div_q : cnt - 1'b1;
      end
      if (rise) begin
        sclk <= 1'b1;
      end else if (fall) begin
        sclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: turns a command stream into CS/SCLK/PICO frames and
// returns the POCI bits sampled during each frame, with optional CS-low bursts.
module spi_controller
  import spi_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DIV_W  = 8
) (
  input  logic              sys_clock_i,
  input  logic              sys_reset_ni,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic              cmd_last_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              spi_clock_o,
  output logic              spi_cs_o,
  output logic              spi_pico_o,
  input  logic              spi_poci_i
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  state_t            state;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-1:0] rx;
  logic              last;
  logic [CNT_W-1:0]  bit_cnt;
  logic              poci_s1, poci_s2;
  logic              rise_d1, rise_d2;
  logic              tick, rise, fall, sclk;
  logic              accept, load, restart, clk_en, shift_en;

  assign accept   = cmd_valid_i && cmd_ready_o;
  assign load     = accept && (state == IDLE);
  assign restart  = accept && (state == BURST_WAIT);
  assign clk_en   = state inside {SETUP, SHIFT, HOLD, GAP};
  assign shift_en = (state == SHIFT);

  assign spi_clock_o = sclk ^ CPOL;
  assign spi_pico_o  = tx[DATA_W-1];

  spi_clk_gen #(
    .DIV_W(DIV_W)
  ) u_clk_gen (
    .clock    (sys_clock_i),
    .reset_n  (sys_reset_ni),
    .load     (load),
    .restart  (restart),
    .enable   (clk_en),
    .toggle_en(shift_en),
    .div      (clk_div_i),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall),
    .sclk     (sclk)
  );

  // POCI is sampled two cycles after each rising edge, once it has crossed the synchroniser.
  always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
    if (!sys_reset_ni) begin
      poci_s1 <= 1'b0;
      poci_s2 <= 1'b0;
      rise_d1 <= 1'b0;
      rise_d2 <= 1'b0;
    end else begin
      poci_s1 <= spi_poci_i;
      poci_s2 <= poci_s1;
      rise_d1 <= rise;
      rise_d2 <= rise_d1;
    end
  end

  always_ff @(posedge sys_clock_i or negedge sys_reset_ni) begin
    if (!sys_reset_ni) begin
      state       <= IDLE;
      tx          <= '0;
      rx          <= '0;
      last        <= 1'b0;
      bit_cnt     <= '0;
      spi_cs_o    <= 1'b1;
      cmd_ready_o <= 1'b0;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (rise_d2) begin
        rx <= {rx[DATA_W-2:0], poci_s2};
      end
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (accept) begin
            tx          <= cmd_data_i;
            last        <= cmd_last_i;
            bit_cnt     <= '0;
            spi_cs_o    <= 1'b0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall) begin
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              state <= HOLD;
            end else begin
              tx      <= {tx[DATA_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= rx;
            if (last) begin
              spi_cs_o <= 1'b1;
              state    <= GAP;
            end else begin
              cmd_ready_o <= 1'b1;
              state       <= BURST_WAIT;
            end
          end
        end
        BURST_WAIT: begin
          if (accept) begin
            tx          <= cmd_data_i;
            last        <= cmd_last_i;
            bit_cnt     <= '0;
            cmd_ready_o <= 1'b0;
            state       <= SETUP;
          end
        end
        GAP: begin
          if (tick) begin
            busy_o      <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          spi_cs_o    <= 1'b1;
          cmd_ready_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: loopback and target-model frames
// checked against latency/shape rules computed from the frame definition.
module tb_spi_controller;

  localparam int DATA_W       = 8;
  localparam int DIV_W        = 8;
  localparam int FRAME_HALVES = 2 * DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DIV_W-1:0]  clk_div = 8'd2;
  logic              cmd_valid = 1'b0;
  logic              cmd_last = 1'b0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_ready, rsp_valid, busy, sclk, cs, pico, poci;
  logic [DATA_W-1:0] rsp_data;

  logic              loop = 1'b1;
  logic [DATA_W-1:0] tgt_data = '0;
  logic [DATA_W-1:0] tgt_sr = '0;
  logic              tcs_q = 1'b1;
  logic              tsclk_q = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spi_controller #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .sys_clock_i (clk),
    .sys_reset_ni(rst_n),
    .clk_div_i   (clk_div),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_data_i  (cmd_data),
    .cmd_last_i  (cmd_last),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .spi_clock_o (sclk),
    .spi_cs_o    (cs),
    .spi_pico_o  (pico),
    .spi_poci_i  (poci)
  );

  // Mode-0 target model: loads its byte when CS falls, shifts on each SCLK fall.
  assign poci = loop ? pico : tgt_sr[DATA_W-1];

  always @(cs, sclk) begin
    if (tcs_q && !cs) tgt_sr = tgt_data;
    else if (!cs && tsclk_q && !sclk) tgt_sr = {tgt_sr[DATA_W-2:0], 1'b0};
    tcs_q = cs;
    tsclk_q = sclk;
  end

  // Cycle-stamped observation of the link, sampled on the falling sys edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   cs_fall_cyc = 0, cs_rise_cyc = 0, cs_rises = 0;
  int   rsp_cnt = 0, rsp_cyc = 0, ready_lowcs = 0;
  logic [DATA_W-1:0] rsp_last = '0;
  int   rise_q[$];
  bit   pico_q[$];
  bit   stable_q[$];
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_pico = 1'b0;

  always @(negedge clk) begin
    if (prev_cs && !cs) cs_fall_cyc = cyc;
    if (!prev_cs && cs) begin cs_rise_cyc = cyc; cs_rises++; end
    if (rsp_valid === 1'b1) begin rsp_cnt++; rsp_cyc = cyc; rsp_last = rsp_data; end
    if (cmd_ready === 1'b1 && cs === 1'b0) ready_lowcs++;
    if (!prev_sclk && sclk) begin
      rise_q.push_back(cyc);
      pico_q.push_back(pico);
      stable_q.push_back(pico == prev_pico);
    end
    prev_cs = cs;
    prev_sclk = sclk;
    prev_pico = pico;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "[TB] watchdog");
  end

  function automatic int exp_latency(input int h);
    return h * FRAME_HALVES + 1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [DATA_W-1:0] d, input logic l, input logic [DIV_W-1:0] div,
                       input bit hold_valid, output int acc, output bit ok);
    ok = 1'b0;
    acc = -1;
    cmd_data = d;
    cmd_last = l;
    clk_div = div;
    cmd_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (cmd_ready === 1'b1) begin acc = cyc + 1; ok = 1'b1; break; end
      step();
    end
    step();
    if (!hold_valid) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (rsp_cnt > base) begin ok = 1'b1; break; end
      step();
    end
  endtask

  // Counts SCLK periods differing from 2*h and PICO bits that were wrong or moving at a rise.
  task automatic frame_shape(input int rb, input int h, input logic [DATA_W-1:0] d,
                             output int bad_period, output int bad_pico);
    bad_period = 0;
    bad_pico = 0;
    for (int i = 1; i < DATA_W; i++)
      if (rb + i >= rise_q.size() || rise_q[rb+i] - rise_q[rb+i-1] != 2 * h) bad_period++;
    for (int i = 0; i < DATA_W; i++)
      if (rb + i >= pico_q.size() || pico_q[rb+i] !== d[DATA_W-1-i] || !stable_q[rb+i]) bad_pico++;
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_checks++;
    if ({cs, sclk, pico, rsp_valid, busy, cmd_ready} !== 6'b100000)
      $display("FAIL reset_outputs: got cs,sclk,pico,rsp_valid,busy,ready=%b want 100000",
               {cs, sclk, pico, rsp_valid, busy, cmd_ready});
    else n_pass++;
    n_checks++;
    if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 00", rsp_data);
    else n_pass++;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({cmd_ready, busy, cs} !== 3'b101)
      $display("FAIL reset_idle: got ready,busy,cs=%b want 101", {cmd_ready, busy, cs});
    else n_pass++;
  endtask

  task automatic test_loopback();
    int acc, rb, r0, rl0, bp, bq;
    bit ok;
    logic [DATA_W-1:0] d = 8'hA5;
    loop = 1'b1;
    rb = rise_q.size(); r0 = rsp_cnt; rl0 = ready_lowcs;
    issue(d, 1'b1, 8'd2, 1'b0, acc, ok);
    if (ok) wait_rsp(r0, ok);
    n_checks++;
    if (!ok) $display("FAIL loop_timeout: got no response, want one"); else n_pass++;
    n_checks++;
    if (rsp_last !== d) $display("FAIL loop_rsp: got %h want %h", rsp_last, d); else n_pass++;
    n_checks++;
    if (rsp_cyc - acc + 1 != exp_latency(3))
      $display("FAIL loop_latency: got %0d want %0d", rsp_cyc - acc + 1, exp_latency(3));
    else n_pass++;
    n_checks++;
    if (cs_rise_cyc - cs_fall_cyc != 3 * FRAME_HALVES)
      $display("FAIL loop_cs_low: got %0d want %0d", cs_rise_cyc - cs_fall_cyc, 3 * FRAME_HALVES);
    else n_pass++;
    n_checks++;
    if (rise_q.size() - rb != DATA_W)
      $display("FAIL loop_pulses: got %0d want %0d", rise_q.size() - rb, DATA_W);
    else n_pass++;
    frame_shape(rb, 3, d, bp, bq);
    n_checks++;
    if (bp != 0) $display("FAIL loop_period: got %0d bad periods want 0", bp); else n_pass++;
    n_checks++;
    if (bq != 0) $display("FAIL loop_pico: got %0d bad bits want 0", bq); else n_pass++;
    n_checks++;
    if (ready_lowcs != rl0) $display("FAIL loop_ready: got %0d ready cycles want 0", ready_lowcs - rl0);
    else n_pass++;
  endtask

  task automatic test_target();
    int acc, rb, r0, bp, bq;
    bit ok;
    logic sclk_before;
    loop = 1'b0;
    tgt_data = 8'h3C;
    rb = rise_q.size(); r0 = rsp_cnt;
    sclk_before = sclk;
    issue(8'h81, 1'b1, 8'd3, 1'b0, acc, ok);
    if (ok) wait_rsp(r0, ok);
    repeat (6) step();
    n_checks++;
    if (!ok) $display("FAIL target_timeout: got no response, want one"); else n_pass++;
    n_checks++;
    if (rsp_last !== 8'h3C || rsp_data !== 8'h3C)
      $display("FAIL target_rsp: got %h/%h want 3c", rsp_last, rsp_data);
    else n_pass++;
    n_checks++;
    if (rsp_cyc - acc + 1 != exp_latency(4))
      $display("FAIL target_latency: got %0d want %0d", rsp_cyc - acc + 1, exp_latency(4));
    else n_pass++;
    n_checks++;
    if ({sclk_before, sclk} !== 2'b00) $display("FAIL target_sclk_idle: got %b want 00", {sclk_before, sclk});
    else n_pass++;
    frame_shape(rb, 4, 8'h81, bp, bq);
    n_checks++;
    if (bp + bq != 0) $display("FAIL target_shape: got %0d bad periods/bits want 0", bp + bq);
    else n_pass++;
    loop = 1'b1;
  endtask

  task automatic test_burst();
    int acc1, acc2, r0, rl0, cr0, rsp1c;
    bit ok1, ok2;
    logic [DATA_W-1:0] rsp1;
    loop = 1'b1;
    r0 = rsp_cnt; rl0 = ready_lowcs; cr0 = cs_rises;
    issue(8'h11, 1'b0, 8'd2, 1'b0, acc1, ok1);
    if (ok1) wait_rsp(r0, ok1);
    rsp1 = rsp_last; rsp1c = rsp_cyc;
    n_checks++;
    if ({cs, cmd_ready} !== 2'b01) $display("FAIL burst_wait: got cs,ready=%b want 01", {cs, cmd_ready});
    else n_pass++;
    repeat ($urandom_range(1, 4)) step();
    issue(8'h22, 1'b1, 8'd6, 1'b0, acc2, ok2);
    if (ok2) wait_rsp(r0 + 1, ok2);
    n_checks++;
    if (!(ok1 && ok2)) $display("FAIL burst_timeout: got ok=%b%b want 11", ok1, ok2); else n_pass++;
    n_checks++;
    if (rsp1 !== 8'h11 || rsp_last !== 8'h22)
      $display("FAIL burst_rsp: got %h,%h want 11,22", rsp1, rsp_last);
    else n_pass++;
    n_checks++;
    if (rsp_cnt - r0 != 2 || cs_rises - cr0 != 1)
      $display("FAIL burst_counts: got rsp=%0d cs_rises=%0d want 2,1", rsp_cnt - r0, cs_rises - cr0);
    else n_pass++;
    n_checks++;
    if (ready_lowcs - rl0 != acc2 - rsp1c)
      $display("FAIL burst_ready: got %0d want %0d", ready_lowcs - rl0, acc2 - rsp1c);
    else n_pass++;
    n_checks++;
    if (rsp_cyc - acc2 + 1 != exp_latency(3))
      $display("FAIL burst_latency2: got %0d want %0d", rsp_cyc - acc2 + 1, exp_latency(3));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, r0, h, rsp1c, rise1;
    bit ok;
    logic [DATA_W-1:0] d1, d2, rsp1;
    loop = 1'b1;
    h = $urandom_range(3, 5);
    d1 = DATA_W'($urandom); d2 = DATA_W'($urandom);
    r0 = rsp_cnt;
    issue(d1, 1'b1, DIV_W'(h - 1), 1'b1, acc1, ok);
    issue(d2, 1'b1, DIV_W'(h - 1), 1'b0, acc2, ok);
    rsp1 = rsp_last; rsp1c = rsp_cyc; rise1 = cs_rise_cyc;
    n_checks++;
    if (rsp_cnt - r0 != 1 || rsp1 !== d1)
      $display("FAIL b2b_first: got cnt=%0d rsp=%h want 1,%h", rsp_cnt - r0, rsp1, d1);
    else n_pass++;
    n_checks++;
    if (acc2 - rsp1c < h + 1)
      $display("FAIL b2b_accept_gap: got %0d want >=%0d", acc2 - rsp1c, h + 1);
    else n_pass++;
    n_checks++;
    if (cs_fall_cyc - rise1 < h)
      $display("FAIL b2b_cs_high: got %0d want >=%0d", cs_fall_cyc - rise1, h);
    else n_pass++;
    if (ok) wait_rsp(r0 + 1, ok);
    n_checks++;
    if (!ok || rsp_last !== d2) $display("FAIL b2b_second: got %h ok=%b want %h", rsp_last, ok, d2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int acc, rb, r0;
    bit ok;
    bit reached = 1'b0;
    loop = 1'b1;
    rb = rise_q.size(); r0 = rsp_cnt;
    issue(8'hC3, 1'b1, 8'd2, 1'b0, acc, ok);
    for (int i = 0; i < 300; i++) begin
      if (rise_q.size() - rb >= 4) begin reached = 1'b1; break; end
      step();
    end
    n_checks++;
    if (!reached || sclk !== 1'b1) $display("FAIL rstmid_reach: got reached=%b sclk=%b want 1,1", reached, sclk);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs, sclk, busy} !== 3'b100) $display("FAIL rstmid_async: got cs,sclk,busy=%b want 100", {cs, sclk, busy});
    else n_pass++;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    n_checks++;
    if (rsp_cnt != r0 || cmd_ready !== 1'b1)
      $display("FAIL rstmid_norsp: got rsp=%0d ready=%b want 0,1", rsp_cnt - r0, cmd_ready);
    else n_pass++;
    r0 = rsp_cnt;
    issue(8'h5A, 1'b1, 8'd2, 1'b0, acc, ok);
    if (ok) wait_rsp(r0, ok);
    n_checks++;
    if (!ok || rsp_last !== 8'h5A || rsp_cyc - acc + 1 != exp_latency(3))
      $display("FAIL rstmid_next: got %h lat=%0d want 5a lat=%0d", rsp_last, rsp_cyc - acc + 1, exp_latency(3));
    else n_pass++;
  endtask

  task automatic test_div_change();
    int acc, rb, r0, bp, bq;
    bit ok;
    logic [DATA_W-1:0] d;
    loop = 1'b1;
    d = DATA_W'($urandom);
    rb = rise_q.size(); r0 = rsp_cnt;
    issue(d, 1'b1, 8'd2, 1'b0, acc, ok);
    repeat (5) step();
    clk_div = 8'd7;
    if (ok) wait_rsp(r0, ok);
    frame_shape(rb, 3, d, bp, bq);
    n_checks++;
    if (!ok || rsp_cyc - acc + 1 != exp_latency(3) || bp != 0)
      $display("FAIL divchg_current: got lat=%0d badp=%0d want %0d,0", rsp_cyc - acc + 1, bp, exp_latency(3));
    else n_pass++;
    repeat (6) step();
    d = DATA_W'($urandom);
    rb = rise_q.size(); r0 = rsp_cnt;
    issue(d, 1'b1, 8'd7, 1'b0, acc, ok);
    if (ok) wait_rsp(r0, ok);
    frame_shape(rb, 8, d, bp, bq);
    n_checks++;
    if (!ok || rsp_cyc - acc + 1 != exp_latency(8) || bp != 0 || rsp_last !== d)
      $display("FAIL divchg_next: got lat=%0d badp=%0d rsp=%h want %0d,0,%h",
               rsp_cyc - acc + 1, bp, rsp_last, exp_latency(8), d);
    else n_pass++;
  endtask

  task automatic test_random();
    int acc, r0, h, burst_h;
    bit ok, in_burst;
    logic [DATA_W-1:0] d, exp;
    logic l;
    logic [DIV_W-1:0] div;
    in_burst = 1'b0;
    burst_h = 0;
    for (int k = 0; k < 10; k++) begin
      d = DATA_W'($urandom);
      l = (k == 9) ? 1'b1 : 1'($urandom_range(0, 1));
      div = DIV_W'($urandom_range(2, 5));
      h = in_burst ? burst_h : int'(div) + 1;
      loop = in_burst ? 1'b1 : 1'($urandom_range(0, 1));
      tgt_data = DATA_W'($urandom);
      exp = loop ? d : tgt_data;
      r0 = rsp_cnt;
      issue(d, l, div, 1'b0, acc, ok);
      if (ok) wait_rsp(r0, ok);
      n_checks++;
      if (!ok || rsp_last !== exp || rsp_cyc - acc + 1 != exp_latency(h) || cs !== l)
        $display("FAIL rand_frame%0d: got rsp=%h lat=%0d cs=%b want %h,%0d,%b",
                 k, rsp_last, rsp_cyc - acc + 1, cs, exp, exp_latency(h), l);
      else n_pass++;
      in_burst = !l;
      burst_h = h;
      repeat ($urandom_range(0, 3)) step();
    end
    loop = 1'b1;
  endtask

  initial begin
    $display("[TB] spi_controller bench start");
    test_reset();
    test_loopback();
    test_target();
    test_burst();
    repeat (10) step();
    test_back_to_back();
    repeat (10) step();
    test_reset_mid();
    repeat (10) step();
    test_div_change();
    repeat (10) step();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
